// File: rtl/dircc_rts_pkg.sv
// dircc_rts_pkg: shared types and constants for the RTS scheduler
// Provides the default device/port geometry, the port-mask type, the
// queue entry layout {address, ports} and the "no ports requested" constant.
package dircc_rts_pkg;
    localparam int RTS_NUM_DEVICES = 16;
    localparam int RTS_ADDR_WIDTH  = $clog2(RTS_NUM_DEVICES);
    localparam int RTS_NUM_PORTS   = 4;
    typedef logic [RTS_NUM_PORTS-1:0] rts_port_mask_t;
    typedef struct packed {
        logic [RTS_ADDR_WIDTH-1:0] address;
        rts_port_mask_t            ports;
    } rts_entry_t;
    localparam rts_port_mask_t RTS_PORT_NONE = '0;
endpackage

// File: rtl/dircc_rts_fifo.sv
// dircc_rts_fifo: synchronous first-word-fall-through FIFO with occupancy count
// Ports: clk, reset_n (async active-low), push/wdata write side,
// pop/rdata read side (rdata shows the head while !empty), empty, full, count.
// The caller only pushes when !full or popping, and only pops when !empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module dircc_rts_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wdata;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push != pop) count <= push ? count + CW'(1) : count - CW'(1);
        end
endmodule

// File: rtl/dircc_rts_scheduler.sv
// dircc_rts_scheduler: ready-to-send evaluation and de-duplicated RTS queue
// Ports: clk, reset_n (async active-low);
//   eval_* : one device state per cycle from the thread-context scanner;
//   clear_valid/clear_address : dispatcher finished a device, drop its pending bit;
//   rts_valid/rts_ready/rts_address/rts_ports : head of queue to the dispatcher;
//   pending_count : queue occupancy; overflow : sticky, a ready device was dropped.
// Optional macro DIRCC_RTS_PRIORITY_EN adds a strict-priority high queue selected
// by eval_priority; pending_count then widens to hold the sum of both queues.
module dircc_rts_scheduler
    import dircc_rts_pkg::*;
#(
    parameter int  NUM_DEVICES = RTS_NUM_DEVICES,
    parameter int  ADDR_WIDTH  = $clog2(NUM_DEVICES),
    parameter int  NUM_PORTS   = RTS_NUM_PORTS,
    parameter int  COUNT_WIDTH = 32,
    parameter int  FIFO_DEPTH  = 8,
`ifdef DIRCC_RTS_PRIORITY_EN
    localparam int PCW         = $clog2(2 * FIFO_DEPTH + 1)
`else
    localparam int PCW         = $clog2(FIFO_DEPTH + 1)
`endif
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   eval_valid,
    input  logic [ADDR_WIDTH-1:0]  eval_address,
    input  logic [COUNT_WIDTH-1:0] eval_count,
    input  logic [COUNT_WIDTH-1:0] eval_count_limit,
    input  logic                   eval_sent,
    input  logic                   eval_running,
    input  logic [NUM_PORTS-1:0]   eval_port_mask,
    input  logic                   eval_priority,
    input  logic                   clear_valid,
    input  logic [ADDR_WIDTH-1:0]  clear_address,
    output logic                   rts_valid,
    input  logic                   rts_ready,
    output logic [ADDR_WIDTH-1:0]  rts_address,
    output logic [NUM_PORTS-1:0]   rts_ports,
    output logic [PCW-1:0]         pending_count,
    output logic                   overflow
);
    localparam int EW  = ADDR_WIDTH + NUM_PORTS;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    logic [NUM_DEVICES-1:0] pending;
    logic [NUM_DEVICES-1:0] pend_clr;
    logic                   eval_ok;
    logic                   push_req;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   head_valid;
    logic [EW-1:0]          wdata;
    logic [EW-1:0]          head;

    assign eval_ok = eval_valid
                  && ({1'b0, eval_address} < (ADDR_WIDTH + 1)'(NUM_DEVICES))
                  && eval_running && !eval_sent
                  && (eval_count == eval_count_limit)
                  && (eval_port_mask != NUM_PORTS'(RTS_PORT_NONE));

    // The clear lands before evaluation so a same-cycle clear+eval re-enqueues.
    always_comb begin
        pend_clr = pending;
        if (clear_valid && ({1'b0, clear_address} < (ADDR_WIDTH + 1)'(NUM_DEVICES)))
            pend_clr[clear_address] = 1'b0;
    end

    assign push_req = eval_ok && !pend_clr[eval_address];
    assign pop      = head_valid && rts_ready;
    assign drop     = push_req && !push;
    assign wdata    = {eval_address, eval_port_mask};

    // Outputs are forced to zero while empty so reset presents zeros at once.
    assign rts_valid                = head_valid;
    assign {rts_address, rts_ports} = head_valid ? head : '0;

`ifdef DIRCC_RTS_PRIORITY_EN
    logic           hi_full, hi_empty, hi_push, hi_pop;
    logic           lo_full, lo_empty, lo_push, lo_pop;
    logic [EW-1:0]  hi_rd, lo_rd;
    logic [FCW-1:0] hi_cnt, lo_cnt;

    assign hi_pop        = pop && !hi_empty;
    assign lo_pop        = pop && hi_empty;
    assign hi_push       = push_req && eval_priority && (!hi_full || hi_pop);
    assign lo_push       = push_req && !eval_priority && (!lo_full || lo_pop);
    assign push          = hi_push || lo_push;
    assign head_valid    = !(hi_empty && lo_empty);
    assign head          = hi_empty ? lo_rd : hi_rd;
    assign pending_count = PCW'(hi_cnt) + PCW'(lo_cnt);

    dircc_rts_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo_hi (
        .clk(clk), .reset_n(reset_n), .push(hi_push), .wdata(wdata), .pop(hi_pop),
        .rdata(hi_rd), .empty(hi_empty), .full(hi_full), .count(hi_cnt)
    );
    dircc_rts_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo_lo (
        .clk(clk), .reset_n(reset_n), .push(lo_push), .wdata(wdata), .pop(lo_pop),
        .rdata(lo_rd), .empty(lo_empty), .full(lo_full), .count(lo_cnt)
    );
`else
    logic           full, empty;
    logic [FCW-1:0] cnt;
    logic           unused_priority;

    assign unused_priority = eval_priority;
    assign push            = push_req && (!full || pop);
    assign head_valid      = !empty;
    assign pending_count   = cnt;

    dircc_rts_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset_n(reset_n), .push(push), .wdata(wdata), .pop(pop),
        .rdata(head), .empty(empty), .full(full), .count(cnt)
    );
`endif

    // A dropped device keeps its pending bit clear so the next scan retries it.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= push ? (pend_clr | (NUM_DEVICES'(1) << eval_address)) : pend_clr;
            if (drop) overflow <= 1'b1;
        end
endmodule

// File: tb/tb_dircc_rts_scheduler.sv
// tb_dircc_rts_scheduler: scoreboard bench with a queue-based reference model
module tb_dircc_rts_scheduler;
    localparam int ND    = 16;
    localparam int AW    = 4;
    localparam int NP    = 4;
    localparam int CW    = 32;
    localparam int DEPTH = 8;
`ifdef DIRCC_RTS_PRIORITY_EN
    localparam int PCW = $clog2(2 * DEPTH + 1);
`else
    localparam int PCW = $clog2(DEPTH + 1);
`endif

    logic           clk = 1'b0;
    logic           reset_n;
    logic           eval_valid;
    logic [AW-1:0]  eval_address;
    logic [CW-1:0]  eval_count;
    logic [CW-1:0]  eval_count_limit;
    logic           eval_sent;
    logic           eval_running;
    logic [NP-1:0]  eval_port_mask;
    logic           eval_priority;
    logic           clear_valid;
    logic [AW-1:0]  clear_address;
    logic           rts_valid;
    logic           rts_ready;
    logic [AW-1:0]  rts_address;
    logic [NP-1:0]  rts_ports;
    logic [PCW-1:0] pending_count;
    logic           overflow;

    always #5 clk = ~clk;

    dircc_rts_scheduler dut (
        .clk(clk), .reset_n(reset_n),
        .eval_valid(eval_valid), .eval_address(eval_address),
        .eval_count(eval_count), .eval_count_limit(eval_count_limit),
        .eval_sent(eval_sent), .eval_running(eval_running),
        .eval_port_mask(eval_port_mask), .eval_priority(eval_priority),
        .clear_valid(clear_valid), .clear_address(clear_address),
        .rts_valid(rts_valid), .rts_ready(rts_ready),
        .rts_address(rts_address), .rts_ports(rts_ports),
        .pending_count(pending_count), .overflow(overflow)
    );

    typedef struct {int a; int p;} ent_t;

    ent_t hq[$];
    ent_t lq[$];
    ent_t sb[$];
    bit   m_pend[ND];
    bit   m_ovf;
    bit   exp_valid;
    int   exp_cnt;
    bit   exp_ovf;
    ent_t exp_head;
    bit   chk_en;
    int   n_cmp;
    int   n_bad;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endfunction

    // Drives one cycle of stimulus, records what the DUT should show this
    // cycle, then advances the model by the rules: pop, clear, evaluate, push/drop.
    task automatic step(input bit v, input int a, input int cnt, input int lim,
                        input bit sent, input bit run, input int mask, input bit pri,
                        input bit cv, input int ca, input bit rdy);
        ent_t e;
        bit   want;
        bit   hi_t;
        eval_valid       = v;
        eval_address     = AW'(a);
        eval_count       = CW'(cnt);
        eval_count_limit = CW'(lim);
        eval_sent        = sent;
        eval_running     = run;
        eval_port_mask   = NP'(mask);
        eval_priority    = pri;
        clear_valid      = cv;
        clear_address    = AW'(ca);
        rts_ready        = rdy;
        exp_cnt   = hq.size() + lq.size();
        exp_valid = exp_cnt != 0;
        exp_ovf   = m_ovf;
        if (exp_valid) exp_head = (hq.size() != 0) ? hq[0] : lq[0];
        hi_t = 1'b0;
`ifdef DIRCC_RTS_PRIORITY_EN
        hi_t = pri;
`endif
        if (rdy && exp_valid) begin
            sb.push_back(exp_head);
            if (hq.size() != 0) hq.delete(0);
            else lq.delete(0);
        end
        if (cv) m_pend[ca] = 1'b0;
        want = v && a < ND && run && !sent && cnt == lim && mask != 0 && !m_pend[a];
        if (want) begin
            e.a = a;
            e.p = mask;
            if (hi_t ? (hq.size() < DEPTH) : (lq.size() < DEPTH)) begin
                if (hi_t) hq.push_back(e);
                else lq.push_back(e);
                m_pend[a] = 1'b1;
            end else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input int a, input int mask, input bit pri, input bit rdy);
        step(1, a, 5, 5, 0, 1, mask, pri, 0, 0, rdy);
    endtask

    task automatic idle(input bit rdy, input bit cv, input int ca);
        step(0, 0, 0, 0, 0, 0, 0, 0, cv, ca, rdy);
    endtask

    always @(negedge clk) begin
        ent_t e;
        if (chk_en) begin
            chk("rts_valid", rts_valid, exp_valid);
            chk("pending_count", pending_count, exp_cnt);
            chk("overflow", overflow, exp_ovf);
            if (rts_valid && rts_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL handshake: got pop of addr %0d expected no entry at %0t", rts_address, $time);
                end else begin
                    e = sb.pop_front();
                    chk("pop_address", rts_address, e.a);
                    chk("pop_ports", rts_ports, e.p);
                end
            end else if (rts_valid && exp_valid) begin
                chk("head_address", rts_address, exp_head.a);
                chk("head_ports", rts_ports, exp_head.p);
            end
        end
    end

    initial begin
        int thr;
        int lim;
        n_cmp = 0;
        n_bad = 0;
        chk_en = 1'b0;
        reset_n = 1'b0;
        eval_valid = 0; eval_address = '0; eval_count = '0; eval_count_limit = '0;
        eval_sent = 0; eval_running = 0; eval_port_mask = '0; eval_priority = 0;
        clear_valid = 0; clear_address = '0; rts_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", rts_valid, 0);
        chk("reset_address", rts_address, 0);
        chk("reset_ports", rts_ports, 0);
        chk("reset_count", pending_count, 0);
        chk("reset_overflow", overflow, 0);
        reset_n = 1'b1;
        exp_valid = 0; exp_cnt = 0; exp_ovf = 0;
        chk_en = 1'b1;

        ev(3, 5, 0, 0);
        ev(3, 5, 0, 0);
        step(1, 3, 5, 5, 0, 1, 5, 0, 1, 3, 0);
        idle(1, 1, 3);
        idle(1, 0, 0);
        idle(1, 0, 0);
        step(1, 6, 4, 5, 0, 1, 5, 0, 0, 0, 0);
        step(1, 6, 5, 5, 1, 1, 5, 0, 0, 0, 0);
        step(1, 6, 5, 5, 0, 0, 5, 0, 0, 0, 0);
        step(1, 6, 5, 5, 0, 1, 0, 0, 0, 0, 0);
        idle(0, 0, 0);

        for (int i = 4; i < 12; i++) ev(i, i, 0, 0);
        ev(12, 9, 0, 0);
        idle(0, 0, 0);
        idle(1, 0, 0);
        ev(12, 9, 0, 0);
        ev(13, 7, 0, 1);
        idle(0, 0, 0);
        for (int i = 0; i < ND; i++) idle(1, 1, i);

`ifdef DIRCC_RTS_PRIORITY_EN
        ev(1, 3, 0, 0);
        ev(2, 12, 1, 0);
        idle(0, 0, 0);
        idle(1, 1, 1);
        idle(1, 1, 2);
        idle(1, 0, 0);
`endif

        for (int i = 0; i < 3000; i++) begin
            thr = 1 + (i / 500) % 3;
            lim = $urandom % 4;
            step(1, $urandom % ND, ($urandom % 4 != 0) ? lim : $urandom % 4, lim,
                 $urandom % 5 == 0, $urandom % 5 != 0, $urandom % 16, $urandom % 2,
                 $urandom % 3 == 0, $urandom % ND, ($urandom % 4) < thr);
        end

        step(1, 14, 5, 5, 0, 1, 9, 0, 1, 14, 0);
        #3;
        chk_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_reset_valid", rts_valid, 0);
        chk("async_reset_address", rts_address, 0);
        chk("async_reset_ports", rts_ports, 0);
        chk("async_reset_count", pending_count, 0);
        chk("async_reset_overflow", overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
